// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper
//  Description : Wall-clock time keeper (hh:mm:ss) driven by the divider tick.
//                Prescales TICKS_PER_SEC ticks per second. Provides a set/load
//                handshake and carry strobes for downstream stages.
//                Optional alarm compare: define TIME_KEEPER_ALARM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_keeper #(
    parameter int TICKS_PER_SEC = 1,
    parameter int HOUR_MAX      = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run_en,
    input  logic       set_req,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
`ifdef TIME_KEEPER_ALARM_EN
    input  logic       alarm_en,
    input  logic [4:0] al_hh,
    input  logic [5:0] al_mm,
    output logic       alarm_hit,
`endif
    output logic       set_ack,
    output logic       set_err,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_stb,
    output logic       min_stb,
    output logic       hour_stb,
    output logic       day_stb
);

    localparam logic [7:0] c_presc_last = 8'(TICKS_PER_SEC - 1);
    localparam logic [4:0] c_hour_max   = 5'(HOUR_MAX);
    localparam logic [5:0] c_sixty_last = 6'd59;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LOAD     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [4:0] hh_q, hh_d;
    logic [5:0] mm_q, mm_d;
    logic [5:0] ss_q, ss_d;
    logic       sec_stb_q, sec_stb_d;
    logic       min_stb_q, min_stb_d;
    logic       hour_stb_q, hour_stb_d;
    logic       day_stb_q, day_stb_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       count_en;
    logic       load_ok;

    // A pending set request wins over both run_en and an incoming tick.
    assign count_en = (state_q == ST_RUN) && !set_req && tick_in;
    assign load_ok  = (set_hh <= c_hour_max) && (set_mm <= c_sixty_last) &&
                      (set_ss <= c_sixty_last);

    // Next-state logic for the run/hold/load handshake controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (set_req)     state_d = ST_LOAD;
                else if (run_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (set_req)      state_d = ST_LOAD;
                else if (!run_en) state_d = ST_HOLD;
            end
            ST_LOAD:     state_d = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!set_req) state_d = run_en ? ST_RUN : ST_HOLD;
            end
            default:     state_d = ST_HOLD;
        endcase
    end

    // Time datapath: load, prescale and cascaded hh:mm:ss advance with strobes.
    always_comb begin
        presc_d    = presc_q;
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        sec_stb_d  = 1'b0;
        min_stb_d  = 1'b0;
        hour_stb_d = 1'b0;
        day_stb_d  = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        if (state_q == ST_LOAD) begin
            ack_d = 1'b1;
            if (load_ok) begin
                hh_d    = set_hh;
                mm_d    = set_mm;
                ss_d    = set_ss;
                presc_d = 8'd0;
            end else begin
                err_d = 1'b1;
            end
        end else if (count_en) begin
            if (presc_q >= c_presc_last) begin
                presc_d   = 8'd0;
                sec_stb_d = 1'b1;
                if (ss_q == c_sixty_last) begin
                    ss_d      = 6'd0;
                    min_stb_d = 1'b1;
                    if (mm_q == c_sixty_last) begin
                        mm_d       = 6'd0;
                        hour_stb_d = 1'b1;
                        if (hh_q == c_hour_max) begin
                            hh_d      = 5'd0;
                            day_stb_d = 1'b1;
                        end else begin
                            hh_d = hh_q + 5'd1;
                        end
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HOLD;
            presc_q    <= 8'd0;
            hh_q       <= 5'd0;
            mm_q       <= 6'd0;
            ss_q       <= 6'd0;
            sec_stb_q  <= 1'b0;
            min_stb_q  <= 1'b0;
            hour_stb_q <= 1'b0;
            day_stb_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            sec_stb_q  <= sec_stb_d;
            min_stb_q  <= min_stb_d;
            hour_stb_q <= hour_stb_d;
            day_stb_q  <= day_stb_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

`ifdef TIME_KEEPER_ALARM_EN
    logic alarm_q, alarm_d;

    // Alarm fires only on a minute rollover, so a load can never trigger it.
    always_comb begin
        alarm_d = min_stb_d && alarm_en && (hh_d == al_hh) && (mm_d == al_mm);
    end

    // Alarm pulse register, aligned with min_stb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alarm_q <= 1'b0;
        else      alarm_q <= alarm_d;
    end

    assign alarm_hit = alarm_q;
`endif

    assign set_ack  = ack_q;
    assign set_err  = err_q;
    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign sec_stb  = sec_stb_q;
    assign min_stb  = min_stb_q;
    assign hour_stb = hour_stb_q;
    assign day_stb  = day_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_keeper
//  Description : Directed self-checking bench for time_keeper (TICKS_PER_SEC=1
//                main instance, TICKS_PER_SEC=4 prescaler instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0, run_en = 1'b0, set_req = 1'b0;
    logic [4:0] set_hh = '0;
    logic [5:0] set_mm = '0, set_ss = '0;
    logic       set_ack, set_err, sec_stb, min_stb, hour_stb, day_stb;
    logic [4:0] hh;
    logic [5:0] mm, ss;

    logic       tick4 = 1'b0, run4 = 1'b0, req4 = 1'b0;
    logic [4:0] shh4 = '0;
    logic [5:0] smm4 = '0, sss4 = '0;
    logic       ack4, err4, sec4, min4, hour4, day4;
    logic [4:0] hh4;
    logic [5:0] mm4, ss4;

`ifdef TIME_KEEPER_ALARM_EN
    logic       alarm_en = 1'b0;
    logic [4:0] al_hh = 5'd6;
    logic [5:0] al_mm = 6'd30;
    logic       alarm_hit;
    logic       al_en4 = 1'b0;
    logic [4:0] al_hh4 = '0;
    logic [5:0] al_mm4 = '0;
    logic       alarm_hit4;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    time_keeper #(.TICKS_PER_SEC(1), .HOUR_MAX(23)) u_dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run_en(run_en),
        .set_req(set_req), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
`ifdef TIME_KEEPER_ALARM_EN
        .alarm_en(alarm_en), .al_hh(al_hh), .al_mm(al_mm), .alarm_hit(alarm_hit),
`endif
        .set_ack(set_ack), .set_err(set_err), .hh(hh), .mm(mm), .ss(ss),
        .sec_stb(sec_stb), .min_stb(min_stb), .hour_stb(hour_stb), .day_stb(day_stb)
    );

    time_keeper #(.TICKS_PER_SEC(4), .HOUR_MAX(23)) u_dut4 (
        .clk(clk), .rst(rst), .tick_in(tick4), .run_en(run4),
        .set_req(req4), .set_hh(shh4), .set_mm(smm4), .set_ss(sss4),
`ifdef TIME_KEEPER_ALARM_EN
        .alarm_en(al_en4), .al_hh(al_hh4), .al_mm(al_mm4), .alarm_hit(alarm_hit4),
`endif
        .set_ack(ack4), .set_err(err4), .hh(hh4), .mm(mm4), .ss(ss4),
        .sec_stb(sec4), .min_stb(min4), .hour_stb(hour4), .day_stb(day4)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tm(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] now();
        return {15'd0, hh, mm, ss};
    endfunction

    function automatic logic [31:0] stbs();
        return {28'd0, sec_stb, min_stb, hour_stb, day_stb};
    endfunction

    // Full load handshake: request, observe the single ack, release.
    task automatic do_load(input string tag, input int h, input int m, input int s,
                           input logic exp_err);
        set_hh = 5'(h); set_mm = 6'(m); set_ss = 6'(s);
        set_req = 1'b1;
        cyc();
        cyc();
        chk({tag, "_ack"}, {31'd0, set_ack}, 32'd1);
        chk({tag, "_err"}, {31'd0, set_err}, {31'd0, exp_err});
        chk({tag, "_nostb"}, stbs(), 32'd0);
        set_req = 1'b0;
        cyc();
        chk({tag, "_ack_drop"}, {31'd0, set_ack}, 32'd0);
    endtask

    initial begin
        cyc(); cyc();
        chk("reset_time", now(), tm(0, 0, 0));
        chk("reset_stb", stbs(), 32'd0);
        chk("reset_ack", {30'd0, set_ack, set_err}, 32'd0);
        rst = 1'b1;
        cyc();

        // Reset mid-count at 12:34:56
        do_load("ld1", 12, 34, 56, 1'b0);
        chk("ld1_time", now(), tm(12, 34, 56));
        run_en = 1'b1;
        cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("pre_rst_time", now(), tm(12, 34, 57));
        chk("pre_rst_stb", stbs(), 32'd8);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_time", now(), tm(0, 0, 0));
        chk("async_rst_stb", stbs(), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            tick_in = 1'b1;
            cyc();
            chk($sformatf("post_rst_tick%0d_ss", i), {26'd0, ss}, 32'(i));
            chk($sformatf("post_rst_tick%0d_stb", i), stbs(), 32'd8);
        end
        tick_in = 1'b0;
        cyc();
        chk("post_rst_idle_stb", stbs(), 32'd0);

        // Midnight rollover
        do_load("ld2", 23, 59, 58, 1'b0);
        tick_in = 1'b1;
        cyc();
        chk("roll1_time", now(), tm(23, 59, 59));
        chk("roll1_stb", stbs(), 32'd8);
        cyc();
        tick_in = 1'b0;
        chk("roll2_time", now(), tm(0, 0, 0));
        chk("roll2_stb", stbs(), 32'hF);
        cyc();
        chk("roll3_stb", stbs(), 32'd0);

        // Prescaler, TICKS_PER_SEC=4
        run4 = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            tick4 = 1'b1;
            cyc();
            chk($sformatf("presc_tick%0d_stb", i + 1), {31'd0, sec4},
                ((i == 3) || (i == 7)) ? 32'd1 : 32'd0);
        end
        tick4 = 1'b0;
        chk("presc_ss", {15'd0, hh4, mm4, ss4}, tm(0, 0, 2));

        // Rejected load held 5 cycles, then valid load
        run_en = 1'b0;
        cyc();
        set_hh = 5'd10; set_mm = 6'd60; set_ss = 6'd0;
        set_req = 1'b1;
        cyc();
        for (int i = 2; i <= 5; i++) begin
            cyc();
            chk($sformatf("bad_hold%0d_ack", i), {30'd0, set_ack, set_err},
                (i == 2) ? 32'd3 : 32'd0);
        end
        set_req = 1'b0;
        cyc();
        chk("bad_time", now(), tm(0, 0, 0));
        do_load("ld3", 7, 15, 30, 1'b0);
        chk("ld3_time", now(), tm(7, 15, 30));

        // Load collides with tick; then HOLD discards ticks
        do_load("ld4", 0, 0, 10, 1'b0);
        run_en = 1'b1;
        cyc();
        set_hh = 5'd1; set_mm = 6'd0; set_ss = 6'd0;
        set_req = 1'b1;
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("coll_notick_time", now(), tm(0, 0, 10));
        chk("coll_notick_stb", stbs(), 32'd0);
        cyc();
        chk("coll_ack", {30'd0, set_ack, set_err}, 32'd2);
        chk("coll_time", now(), tm(1, 0, 0));
        chk("coll_stb", stbs(), 32'd0);
        set_req = 1'b0;
        cyc();
        run_en = 1'b0;
        cyc();
        tick_in = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        tick_in = 1'b0;
        chk("hold_time", now(), tm(1, 0, 0));
        chk("hold_stb", stbs(), 32'd0);

`ifdef TIME_KEEPER_ALARM_EN
        alarm_en = 1'b1;
        do_load("al1", 6, 29, 59, 1'b0);
        chk("al1_load_nohit", {31'd0, alarm_hit}, 32'd0);
        run_en = 1'b1;
        cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("al1_time", now(), tm(6, 30, 0));
        chk("al1_hit", {30'd0, alarm_hit, min_stb}, 32'd3);
        cyc();
        chk("al1_hit_drop", {31'd0, alarm_hit}, 32'd0);
        alarm_en = 1'b0;
        do_load("al2", 6, 29, 59, 1'b0);
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("al2_nohit", {30'd0, alarm_hit, min_stb}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumes the one-cycle tick pulse produced by the clock divider and keeps wall-clock time in hours, minutes and seconds.
- Includes a prescaler: counts TICKS_PER_SEC input ticks per second.
- Provides a set/load handshake for the user-setting logic, and carry strobes for the display and alarm stages downstream.
- Single clock domain, same clock as the divider.

Parameters:
- TICKS_PER_SEC, 1, number of tick_in pulses per second; legal range 1..255.
- HOUR_MAX, 23, last hour value before wrap to 0; legal range 1..31.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
- tick_in  input  1  one-cycle pulse from the clock divider; ignored while not in RUN.
- run_en  input  1  1 = count time; 0 = freeze time (HOLD).
- set_req  input  1  request to load set_hh/set_mm/set_ss; held high until set_ack is seen.
- set_hh  input  5  hour value to load.
- set_mm  input  6  minute value to load.
- set_ss  input  6  second value to load.
- set_ack  output  1  one-cycle acknowledge of a load.
- set_err  output  1  one-cycle pulse, concurrent with set_ack, when the load was rejected.
- hh  output  5  current hour.
- mm  output  6  current minute.
- ss  output  6  current second.
- sec_stb  output  1  one-cycle pulse on every seconds increment.
- min_stb  output  1  one-cycle pulse when seconds wrap 59->0.
- hour_stb  output  1  one-cycle pulse when minutes wrap 59->0.
- day_stb  output  1  one-cycle pulse when hours wrap HOUR_MAX->0.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs and internal state go to 0 and the FSM enters HOLD. This includes hh, mm, ss, all strobes, set_ack, set_err and the prescaler count. Release is sampled on the next rising clk edge.
- FSM states:
  - HOLD: entered on reset, or when run_en=0.
  - RUN: counting.
  - LOAD: one cycle; performs the load and asserts set_ack.
  - WAIT_REL: waits for set_req to fall.
- FSM transitions:
  - HOLD -> RUN when run_en=1 and set_req=0.
  - RUN -> HOLD when run_en=0.
  - HOLD or RUN -> LOAD when set_req=1; this has priority over run_en and over tick_in.
  - LOAD -> WAIT_REL unconditionally.
  - WAIT_REL -> RUN or HOLD per run_en once set_req=0.
- Prescaler (RUN only):
  - tick_in=1 increments the 8-bit prescaler.
  - When the prescaler reaches TICKS_PER_SEC-1 and tick_in=1, it clears to 0 and the seconds advance.
  - With TICKS_PER_SEC=1, every tick advances the seconds.
- Time advance:
  - ss increments; at 59 it wraps to 0 and mm increments.
  - mm at 59 wraps to 0 and hh increments.
  - hh at HOUR_MAX wraps to 0.
  - All cascaded wraps update in the same clock edge; e.g. 23:59:59 -> 00:00:00 in one cycle.
- Strobes:
  - Registered; asserted in the same edge as the counter update, i.e. high for the one cycle following the update edge.
  - Cascaded strobes assert together (sec_stb, min_stb, hour_stb and day_stb all high on the midnight rollover).
- Latency: 1 cycle from tick_in high (at the prescale terminal count) to the updated ss and sec_stb.
- Load:
  - In LOAD, if set_hh<=HOUR_MAX, set_mm<=59 and set_ss<=59: hh/mm/ss take the set values, the prescaler clears to 0, and set_ack=1.
  - Otherwise time is unchanged, and set_ack=1 with set_err=1.
  - No strobes are asserted on a load.
- Tick during LOAD or WAIT_REL: discarded, not queued.
- tick_in in HOLD: discarded; the prescaler is retained.
- Reset mid-load: set_ack is not produced; the requester must re-issue after reset.
- Held set_req produces exactly one set_ack; a new load requires set_req to deassert and reassert.

Optional Feature:
- Macro: TIME_KEEPER_ALARM_EN.
- When defined, adds:
  - Input alarm_en (1).
  - Inputs al_hh (5) and al_mm (6).
  - Output alarm_hit (1).
- alarm_hit is a one-cycle pulse asserted with min_stb when, after the update, alarm_en=1, hh==al_hh, mm==al_mm and ss==0.
- A load never triggers alarm_hit.
- When undefined: these ports are absent and no compare logic is built.

Test Plan:
- Reset at 12:34:56 mid-count, rst=0 -> hh/mm/ss/strobes 0 asynchronously; after release with run_en=1, 3 ticks -> ss=3, three sec_stb pulses.
- Load 23:59:58, run_en=1, TICKS_PER_SEC=1, 2 ticks -> 23:59:59, then 00:00:00 with sec_stb, min_stb, hour_stb and day_stb high in the same single cycle.
- TICKS_PER_SEC=4, 8 ticks from 00:00:00 -> ss=2; sec_stb only on the 4th and 8th tick.
- set_req held 5 cycles with 10:60:00 -> one set_ack with set_err, time unchanged; then valid 07:15:30 -> one set_ack, set_err=0, time=07:15:30.
- set_req and tick_in high in the same cycle at 00:00:10, load 01:00:00 -> time=01:00:00, no sec_stb, tick discarded; run_en=0 then 5 ticks -> time unchanged.
- With TIME_KEEPER_ALARM_EN, al=06:30, alarm_en=1, start at 06:29:59, 1 tick -> alarm_hit one cycle with min_stb; alarm_en=0 repeat -> no alarm_hit.
